bcd_score_keeper: RTL and testbench

Parametrised packed-BCD score register for the GUI score path. It supports add, saturating subtract, clear, and clear-with-high-score, and tracks the session high score. Arithmetic runs one decimal digit per clock behind a start/busy/done handshake, so wide scores do not need a long combinational carry chain. The block sits between game-event logic, which issues score deltas, and the score-display digit renderers.

---
 rtl/score_pkg.sv | 20 ++
 rtl/bcd_digit_alu.sv | 44 ++++
 rtl/bcd_score_keeper.sv | 181 ++++++++++++++++++
 tb/tb_bcd_score_keeper.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the packed-BCD score keeper.
package score_pkg;

    localparam int DEFAULT_DIGITS = 6;
    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        ADD       = 2'b00,
        SUB       = 2'b01,
        CLEAR     = 2'b10,
        CLEAR_ALL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        COMMIT = 2'b10
    } state_t;

endpackage

// File: rtl/bcd_digit_alu.sv
// Single-digit BCD add/subtract with carry/borrow; flags operand digits above 9.
module bcd_digit_alu
    import score_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] y,
    output logic       cout,
    output logic       bad
);

    logic [4:0] sum;
    logic [4:0] diff;
    logic [4:0] sum_adj;

    // a - b - cin spans -16..15, so bit 4 of the 5-bit difference is its sign
    assign sum     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign diff    = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
    assign sum_adj = sum - 5'd10;
    assign bad     = (b > BCD_NINE);

    always_comb begin
        y    = 4'd0;
        cout = 1'b0;
        if (sub) begin
            if (diff[4]) begin
                y    = diff[3:0] + 4'd10;
                cout = 1'b1;
            end else begin
                y    = diff[3:0];
            end
        end else begin
            if (sum > 5'd9) begin
                y    = sum_adj[3:0];
                cout = 1'b1;
            end else begin
                y    = sum[3:0];
            end
        end
    end

endmodule

// File: rtl/bcd_score_keeper.sv
// Packed-BCD score register with high-score tracking; arithmetic runs one digit
// per clock through a shared digit ALU, and the visible score changes only at COMMIT.
module bcd_score_keeper
    import score_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [4*DIGITS-1:0]   amountIn,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   resultOut,
    output logic [4*DIGITS-1:0]   highScoreOut,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  badDigit
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

    state_t             state_q, state_d;
    op_t                op_q;
    logic [W-1:0]       amount_q;
    logic [W-1:0]       work_q, work_d;
    logic [W-1:0]       result_q;
    logic [W-1:0]       high_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               bad_pending_q;
    logic               done_q;
    logic               overflow_q, underflow_q, bad_digit_q;

    logic [3:0]         res_dig [DIGITS];
    logic [3:0]         amt_dig [DIGITS];
    logic [3:0]         alu_y;
    logic               alu_cout;
    logic               alu_bad;
    logic               accept;
    logic               last_digit;

    logic [W-1:0]       commit_result;
    logic               commit_ovf, commit_unf;

    assign accept     = (state_q == IDLE) && start;
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

    // Digit views feed the single ALU; the working register captures digit idx_q only
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign res_dig[gi] = result_q[gi*4 +: 4];
            assign amt_dig[gi] = amount_q[gi*4 +: 4];
            assign work_d[gi*4 +: 4] = ((state_q == RUN) && (idx_q == IDX_W'(gi)))
                                       ? alu_y : work_q[gi*4 +: 4];
        end
    endgenerate

    bcd_digit_alu u_alu (
        .a    (res_dig[idx_q]),
        .b    (amt_dig[idx_q]),
        .cin  (carry_q),
        .sub  (op_q == SUB),
        .y    (alu_y),
        .cout (alu_cout),
        .bad  (alu_bad)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((op_t'(op) == ADD) || (op_t'(op) == SUB)) begin
                        state_d = RUN;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // Rejection beats saturation; CLEAR ops never run digits, so carry_q is 0 for them
    always_comb begin
        commit_result = work_q;
        commit_ovf    = 1'b0;
        commit_unf    = 1'b0;
        if (bad_pending_q) begin
            commit_result = result_q;
        end else if ((op_q == CLEAR) || (op_q == CLEAR_ALL)) begin
            commit_result = '0;
        end else if ((op_q == ADD) && carry_q) begin
            commit_result = ALL_NINES;
            commit_ovf    = 1'b1;
        end else if ((op_q == SUB) && carry_q) begin
            commit_result = '0;
            commit_unf    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            op_q          <= ADD;
            amount_q      <= '0;
            work_q        <= '0;
            result_q      <= '0;
            high_q        <= '0;
            idx_q         <= '0;
            carry_q       <= 1'b0;
            bad_pending_q <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            bad_digit_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            work_q <= work_d;
            if (accept) begin
                op_q          <= op_t'(op);
                amount_q      <= amountIn;
                idx_q         <= '0;
                carry_q       <= 1'b0;
                bad_pending_q <= 1'b0;
                overflow_q    <= 1'b0;
                underflow_q   <= 1'b0;
                bad_digit_q   <= 1'b0;
            end
            if (state_q == RUN) begin
                carry_q <= alu_cout;
                idx_q   <= idx_q + IDX_W'(1);
                if (alu_bad) begin
                    bad_pending_q <= 1'b1;
                end
            end
            if (state_q == COMMIT) begin
                result_q    <= commit_result;
                done_q      <= 1'b1;
                overflow_q  <= commit_ovf;
                underflow_q <= commit_unf;
                bad_digit_q <= bad_pending_q;
                if (op_q == CLEAR_ALL) begin
                    high_q <= '0;
                end else if (commit_result > high_q) begin
                    high_q <= commit_result;
                end
            end
        end
    end

    assign done         = done_q;
    assign resultOut    = result_q;
    assign highScoreOut = high_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign badDigit     = bad_digit_q;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Directed self-checking bench for bcd_score_keeper with DIGITS=6.
module tb_bcd_score_keeper;

    localparam int DIGITS = 6;
    localparam int W      = 4 * DIGITS;

    logic          clk;
    logic          resetN;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  amountIn;
    logic          busy;
    logic          done;
    logic [W-1:0]  resultOut;
    logic [W-1:0]  highScoreOut;
    logic          overflow;
    logic          underflow;
    logic          badDigit;

    int check_cnt;
    int error_cnt;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_CLA = 2'b11;

    bcd_score_keeper #(.DIGITS(DIGITS)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .start        (start),
        .op           (op),
        .amountIn     (amountIn),
        .busy         (busy),
        .done         (done),
        .resultOut    (resultOut),
        .highScoreOut (highScoreOut),
        .overflow     (overflow),
        .underflow    (underflow),
        .badDigit     (badDigit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            error_cnt++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Issues one op, measures latency and busy cycles, then checks score, high score and flags.
    // Returns in the done cycle so the next call exercises back-to-back acceptance.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] amt,
                          input int exp_lat, input logic [W-1:0] exp_res, input logic [W-1:0] exp_high,
                          input logic exp_ovf, input logic exp_unf, input logic exp_bad);
        int lat;
        int busy_cnt;
        bit got_done;
        lat = 0;
        busy_cnt = 0;
        got_done = 0;
        @(negedge clk);
        start = 1'b1;
        op = o;
        amountIn = amt;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = OP_CLA;
        amountIn = '1;
        check_eq({tag, " done_low_after_start"}, {31'd0, done}, 32'd0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                got_done = 1;
                break;
            end
        end
        check_eq({tag, " done_seen"}, {31'd0, got_done}, 32'd1);
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " busy_cycles"}, busy_cnt, exp_lat);
        check_eq({tag, " busy_low_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " result"}, {8'd0, resultOut}, {8'd0, exp_res});
        check_eq({tag, " high"}, {8'd0, highScoreOut}, {8'd0, exp_high});
        check_eq({tag, " flags"}, {29'd0, overflow, underflow, badDigit},
                 {29'd0, exp_ovf, exp_unf, exp_bad});
        $display("op %s: result=%h high=%h lat=%0d flags=%b%b%b", tag, resultOut, highScoreOut,
                 lat, overflow, underflow, badDigit);
    endtask

    initial begin
        int done_cnt;
        check_cnt = 0;
        error_cnt = 0;
        resetN = 1'b0;
        start = 1'b0;
        op = OP_ADD;
        amountIn = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset result", {8'd0, resultOut}, 32'd0);
        check_eq("reset high", {8'd0, highScoreOut}, 32'd0);
        check_eq("reset busy_done", {30'd0, busy, done}, 32'd0);
        check_eq("reset flags", {29'd0, overflow, underflow, badDigit}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        run_op("add123", OP_ADD, 24'h000123, 7, 24'h000123, 24'h000123, 0, 0, 0);
        run_op("add999", OP_ADD, 24'h000999, 7, 24'h001122, 24'h001122, 0, 0, 0);

        run_op("clrall1", OP_CLA, 24'h000000, 1, 24'h000000, 24'h000000, 0, 0, 0);
        run_op("add50", OP_ADD, 24'h000050, 7, 24'h000050, 24'h000050, 0, 0, 0);
        run_op("sub100", OP_SUB, 24'h000100, 7, 24'h000000, 24'h000050, 0, 1, 0);

        run_op("add999990", OP_ADD, 24'h999990, 7, 24'h999990, 24'h999990, 0, 0, 0);
        run_op("add20_ovf", OP_ADD, 24'h000020, 7, 24'h999999, 24'h999999, 1, 0, 0);

        run_op("clrall2", OP_CLA, 24'h000000, 1, 24'h000000, 24'h000000, 0, 0, 0);
        run_op("add800", OP_ADD, 24'h000800, 7, 24'h000800, 24'h000800, 0, 0, 0);
        run_op("sub300", OP_SUB, 24'h000300, 7, 24'h000500, 24'h000800, 0, 0, 0);
        run_op("sub200", OP_SUB, 24'h000200, 7, 24'h000300, 24'h000800, 0, 0, 0);
        run_op("clear", OP_CLR, 24'h000000, 1, 24'h000000, 24'h000800, 0, 0, 0);
        run_op("clrall3", OP_CLA, 24'h000000, 1, 24'h000000, 24'h000000, 0, 0, 0);

        run_op("add100", OP_ADD, 24'h000100, 7, 24'h000100, 24'h000100, 0, 0, 0);
        run_op("add_badA1", OP_ADD, 24'h0000A1, 7, 24'h000100, 24'h000100, 0, 0, 1);
        run_op("add_borrowchain", OP_ADD, 24'h000001, 7, 24'h000101, 24'h000101, 0, 0, 0);
        run_op("sub_borrow", OP_SUB, 24'h000002, 7, 24'h000099, 24'h000101, 0, 0, 0);

        // Extra starts while busy must be dropped: one done, one +5 update
        @(negedge clk);
        start = 1'b1;
        op = OP_ADD;
        amountIn = 24'h000005;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = (n >= 2 && n <= 5);
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        start = 1'b0;
        check_eq("ignore_start done_count", done_cnt, 1);
        check_eq("ignore_start result", {8'd0, resultOut}, 32'h000104);
        $display("op ignore_start: result=%h dones=%0d", resultOut, done_cnt);

        // Reset mid-op: reach 000100, then abort an ADD 000777 in its third cycle
        run_op("clr_pre_rst", OP_CLR, 24'h000000, 1, 24'h000000, 24'h000104, 0, 0, 0);
        run_op("add100_pre_rst", OP_ADD, 24'h000100, 7, 24'h000100, 24'h000104, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        op = OP_ADD;
        amountIn = 24'h000777;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("midrst result", {8'd0, resultOut}, 32'd0);
        check_eq("midrst high", {8'd0, highScoreOut}, 32'd0);
        check_eq("midrst busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check_eq("midrst no_done", done_cnt, 0);
        check_eq("midrst result_after", {8'd0, resultOut}, 32'd0);
        check_eq("midrst busy_after", {31'd0, busy}, 32'd0);
        $display("op midreset: result=%h high=%h dones=%0d", resultOut, highScoreOut, done_cnt);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
